regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Command-driven initiator for the lab's 32-entry register file (`register_file`). It accepts WRITE, READ, COPY and CLEAR commands over a valid/ready handshake. It sequences the register file's `ra0`/`ra1`/`wa`/`we`/`wd` ports cycle by cycle and returns read data with a one-cycle response pulse. It sits between a host (switch/UART front end or testbench) and the register file.

## Interface
- `WIDTH`, 32: data width; must equal the register file width.
- `ADDR_W`, 5: address width; depth = 2^ADDR_W.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  00 WRITE, 01 READ, 10 CLEAR, 11 COPY.
- `cmd_a`  in  ADDR_W  WRITE/READ/COPY source address.
- `cmd_b`  in  ADDR_W  READ second address / COPY destination.
- `cmd_data`  in  WIDTH  WRITE data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_op`  out  2  op of the completed command.
- `rsp_data0`  out  WIDTH  READ: value at a; COPY: copied value; else 0.
- `rsp_data1`  out  WIDTH  READ: value at b; else 0.
- `busy`  out  1  high in any state other than IDLE.
- `ra0`, `ra1`, `wa`  out  ADDR_W  register file address ports.
- `we`  out  1  register file write enable.
- `wd`  out  WIDTH  register file write data.
- `rd0`, `rd1`  in  WIDTH  register file read data; combinational from `ra0`/`ra1`.

## Operation
- The register file reads asynchronously and writes on the rising `clk` edge when `we`=1.
- FSM states: IDLE, WRITE, READ, COPY, CLEAR, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`, latch op/a/b/data and go to the op state.
  - All regfile outputs are 0 (`we`=0).
- WRITE (1 cycle): `we`=1, `wa`=a, `wd`=data. Next state RESP.
- READ (1 cycle): `ra0`=a, `ra1`=b. Register `rd0`/`rd1` into `rsp_data0`/`rsp_data1` at the cycle end. Next state RESP.
- COPY (1 cycle):
  - `ra0`=a, `we`=1, `wa`=b, `wd`=`rd0` (combinational path).
  - Register `rd0` into `rsp_data0`. Next state RESP.
  - a==b is legal: the entry rewrites its own value.
- CLEAR (2^ADDR_W cycles):
  - Counter `cnt` starts at 0; `we`=1, `wa`=`cnt`, `wd`=0.
  - `cnt` increments each cycle. After `cnt`=2^ADDR_W−1 is written, go to RESP.
  - `cnt` does not wrap back into CLEAR.
- RESP (1 cycle):
  - `rsp_valid`=1, `rsp_op`=latched op, `cmd_ready`=0, `we`=0. Next state IDLE.
  - `rsp_data0`/`rsp_data1` hold until the next RESP. WRITE and CLEAR load 0 into both.
- `cmd_valid` outside IDLE is ignored: nothing is latched. The host must hold the command until it sees `cmd_ready`.
- Command fields are latched at acceptance. Changes to `cmd_*` after acceptance have no effect.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1, `busy`=0, `rsp_valid`=0.
  - `rsp_op`=0, `rsp_data0`=`rsp_data1`=0.
  - `ra0`=`ra1`=`wa`=0, `we`=0, `wd`=0, `cnt`=0.
- Acceptance at edge N:
  - WRITE/READ/COPY: op state during cycle N+1, `rsp_valid` during cycle N+2, `cmd_ready` high again in cycle N+3.
  - CLEAR: `we`=1 during cycles N+1..N+32; `rsp_valid` during N+33.
- Peak throughput: one single-cycle command per 3 cycles.
- Regfile outputs are decoded from registered state and latched fields. They are glitch-free relative to `clk` except COPY `wd`, which follows `rd0`.
- Reset mid-operation (any state, including mid-CLEAR):
  - The next edge returns to IDLE and `we`=0 from the following cycle.
  - No response is issued; entries already cleared stay cleared.
- Reset has priority over command acceptance in the same cycle.

## Test plan
- Reset, then WRITE a=0x03 data=0x12345678 → `we`=1 one cycle with `wa`=0x03; `rsp_valid` pulse 2 cycles after acceptance with `rsp_op`=00.
- WRITE 0x12←0x87654321, then READ a=0x03 b=0x12 → `rsp_data0`=0x12345678, `rsp_data1`=0x87654321.
- COPY a=0x12 b=0x03, then READ a=0x03 b=0x12 → both 0x87654321; COPY `rsp_data0`=0x87654321.
- CLEAR → exactly 32 `we` cycles with `wa`=0..31 and `wd`=0; `rsp_valid` at N+33; READ 0x03/0x12 → 0/0.
- Assert `rst` after 10 CLEAR cycles → no `rsp_valid`; READ 0x03 → 0 (cleared); READ 0x12 → prior value 0x87654321 retained.
- Hold `cmd_valid` high with WRITE 0x05←0xabcdef01 continuously → accepted only on `cmd_ready` cycles; no capture while `busy`; each acceptance yields exactly one `rsp_valid`.

Source files
------------

// File: rtl/regfile_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_ctrl
//
// Command-driven initiator for a 32-entry asynchronous-read register file.
// A host issues WRITE, READ, COPY and CLEAR commands over a valid/ready
// handshake. The controller drives the register file address, write-enable
// and write-data ports one cycle at a time. Each command completes with a
// single-cycle response pulse that carries any data read back.
//
// Parameters
//   WIDTH   data width, must match the register file
//   ADDR_W  address width, depth = 2**ADDR_W
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_op               00 WRITE, 01 READ, 10 CLEAR, 11 COPY
//   cmd_a, cmd_b         source / second-or-destination address
//   cmd_data             WRITE data
//   rsp_valid            one-cycle completion pulse
//   rsp_op               op of the completed command
//   rsp_data0/1          READ: values at a/b, COPY: copied value/0, else 0/0
//   busy                 high whenever the FSM is not in IDLE
//   ra0, ra1, wa, we, wd register file ports driven by the controller
//   rd0, rd1             register file read data (combinational from ra0/ra1)
// -----------------------------------------------------------------------------
module regfile_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_op,
  output logic [WIDTH-1:0]  rsp_data0,
  output logic [WIDTH-1:0]  rsp_data1,
  output logic              busy,
  output logic [ADDR_W-1:0] ra0,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] wa,
  output logic              we,
  output logic [WIDTH-1:0]  wd,
  input  logic [WIDTH-1:0]  rd0,
  input  logic [WIDTH-1:0]  rd1
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_COPY  = 3'd3,
    S_CLEAR = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;
  logic [WIDTH-1:0]  data_q;
  logic [ADDR_W-1:0] cnt;

  // ---------------------------------------------------------------------------
  // Control FSM and response registers.
  // Command fields are captured only on acceptance in IDLE, so cmd_* activity
  // while busy can never disturb a command in flight. The data latches carry
  // no reset: they are only observed in states entered through acceptance.
  // rsp_valid is raised on the transition into RESP so it is high exactly
  // during the RESP cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_WRITE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_op    <= 2'b00;
      rsp_data0 <= '0;
      rsp_data1 <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            a_q    <= cmd_a;
            b_q    <= cmd_b;
            data_q <= cmd_data;
            cnt    <= '0;
            case (cmd_op)
              OP_WRITE: state <= S_WRITE;
              OP_READ:  state <= S_READ;
              OP_CLEAR: state <= S_CLEAR;
              default:  state <= S_COPY;
            endcase
          end
        end

        S_WRITE: begin
          rsp_data0 <= '0;
          rsp_data1 <= '0;
          rsp_op    <= op_q;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end

        // rd0/rd1 already reflect ra0/ra1 = a/b during this cycle.
        S_READ: begin
          rsp_data0 <= rd0;
          rsp_data1 <= rd1;
          rsp_op    <= op_q;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end

        // The same rd0 value is written to b and returned to the host.
        S_COPY: begin
          rsp_data0 <= rd0;
          rsp_data1 <= '0;
          rsp_op    <= op_q;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end

        // One entry per cycle; leave after the last address has been written.
        // cnt rolls over to 0 on exit, which is also its idle value.
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            rsp_data0 <= '0;
            rsp_data1 <= '0;
            rsp_op    <= op_q;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file port decode.
  // Driven purely from the state register and latched fields, so the ports
  // only change on clk edges. The one exception is wd during COPY, which is
  // the combinational read path rd0 routed straight back to the write port.
  // ---------------------------------------------------------------------------
  always_comb begin
    ra0 = '0;
    ra1 = '0;
    wa  = '0;
    we  = 1'b0;
    wd  = '0;
    case (state)
      S_WRITE: begin
        we = 1'b1;
        wa = a_q;
        wd = data_q;
      end
      S_READ: begin
        ra0 = a_q;
        ra1 = b_q;
      end
      S_COPY: begin
        ra0 = a_q;
        we  = 1'b1;
        wa  = b_q;
        wd  = rd0;
      end
      S_CLEAR: begin
        we = 1'b1;
        wa = cnt;
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_ctrl
//
// Directed bench for regfile_ctrl. A behavioural 32 x 32 register file
// (asynchronous read, write on rising clk when we) is attached to the
// controller ports. Inputs change and outputs are sampled on the falling
// edge, so every check sees settled values between active edges.
// -----------------------------------------------------------------------------
module tb_regfile_ctrl;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_a;
  logic [ADDR_W-1:0] cmd_b;
  logic [WIDTH-1:0]  cmd_data;
  logic              rsp_valid;
  logic [1:0]        rsp_op;
  logic [WIDTH-1:0]  rsp_data0;
  logic [WIDTH-1:0]  rsp_data1;
  logic              busy;
  logic [ADDR_W-1:0] ra0;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] wa;
  logic              we;
  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  rd0;
  logic [WIDTH-1:0]  rd1;

  int checks = 0;
  int errors = 0;

  // Register file model
  logic [WIDTH-1:0] mem [0:31];
  logic             mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

  regfile_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_op    (rsp_op),
    .rsp_data0 (rsp_data0),
    .rsp_data1 (rsp_data1),
    .busy      (busy),
    .ra0       (ra0),
    .ra1       (ra1),
    .wa        (wa),
    .we        (we),
    .wd        (wd),
    .rd0       (rd0),
    .rd1       (rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for cmd_ready, presents one command for one edge and
  // returns on the falling edge of the cycle after acceptance (cycle N+1).
  task automatic send(input logic [1:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [31:0] d);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Runs a command to completion and returns in the cycle after RESP.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [31:0] d);
    send(op, a, b, d);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    mem_init  = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    checks++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: ready/busy/rsp_valid=%b required 100",
               {cmd_ready, busy, rsp_valid});
    end
    checks++;
    if ({rsp_op, rsp_data0, rsp_data1} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: op=%h d0=%h d1=%h required 0/0/0",
               rsp_op, rsp_data0, rsp_data1);
    end
    checks++;
    if ({ra0, ra1, wa, we, wd} !== '0) begin
      errors++;
      $display("FAIL reset_rf_ports: ra0=%h ra1=%h wa=%h we=%b wd=%h required all 0",
               ra0, ra1, wa, we, wd);
    end
    // Reset wins over a command presented in the same cycle.
    cmd_op    = 2'b00;
    cmd_a     = 5'h08;
    cmd_data  = 32'h5555aaaa;
    cmd_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    checks++;
    if ({busy, we} !== 2'b00) begin
      errors++;
      $display("FAIL reset_priority: busy/we=%b required 00", {busy, we});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, mem[8]} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_priority_effect: rsp_valid=%b mem8=%h required 0/0",
               rsp_valid, mem[8]);
    end
  endtask

  task automatic test_write;
    send(2'b00, 5'h03, 5'h00, 32'h12345678);
    checks++;
    if ({we, wa, wd} !== {1'b1, 5'h03, 32'h12345678}) begin
      errors++;
      $display("FAIL write_port: we=%b wa=%h wd=%h required 1/03/12345678", we, wa, wd);
    end
    checks++;
    if ({busy, cmd_ready, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL write_busy: busy/ready/rsp=%b required 100", {busy, cmd_ready, rsp_valid});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_op, we, cmd_ready} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL write_rsp: rsp_valid=%b op=%b we=%b ready=%b required 1/00/0/0",
               rsp_valid, rsp_op, we, cmd_ready);
    end
    checks++;
    if ({rsp_data0, rsp_data1} !== 64'h0) begin
      errors++;
      $display("FAIL write_rsp_data: d0=%h d1=%h required 0/0", rsp_data0, rsp_data1);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, mem[3]} !== {2'b01, 32'h12345678}) begin
      errors++;
      $display("FAIL write_done: rsp_valid=%b ready=%b mem3=%h required 0/1/12345678",
               rsp_valid, cmd_ready, mem[3]);
    end
  endtask

  task automatic test_read;
    run_cmd(2'b00, 5'h12, 5'h00, 32'h87654321);
    send(2'b01, 5'h03, 5'h12, 32'h0);
    checks++;
    if ({ra0, ra1, we} !== {5'h03, 5'h12, 1'b0}) begin
      errors++;
      $display("FAIL read_port: ra0=%h ra1=%h we=%b required 03/12/0", ra0, ra1, we);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_op, rsp_data0, rsp_data1} !==
        {1'b1, 2'b01, 32'h12345678, 32'h87654321}) begin
      errors++;
      $display("FAIL read_rsp: v=%b op=%b d0=%h d1=%h required 1/01/12345678/87654321",
               rsp_valid, rsp_op, rsp_data0, rsp_data1);
    end
    @(negedge clk);
    // Response data holds after the pulse.
    checks++;
    if ({rsp_valid, rsp_data0} !== {1'b0, 32'h12345678}) begin
      errors++;
      $display("FAIL read_hold: v=%b d0=%h required 0/12345678", rsp_valid, rsp_data0);
    end
  endtask

  task automatic test_copy;
    send(2'b11, 5'h12, 5'h03, 32'h0);
    checks++;
    if ({ra0, we, wa, wd} !== {5'h12, 1'b1, 5'h03, 32'h87654321}) begin
      errors++;
      $display("FAIL copy_port: ra0=%h we=%b wa=%h wd=%h required 12/1/03/87654321",
               ra0, we, wa, wd);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_op, rsp_data0, rsp_data1} !== {1'b1, 2'b11, 32'h87654321, 32'h0}) begin
      errors++;
      $display("FAIL copy_rsp: v=%b op=%b d0=%h d1=%h required 1/11/87654321/0",
               rsp_valid, rsp_op, rsp_data0, rsp_data1);
    end
    @(negedge clk);
    send(2'b01, 5'h03, 5'h12, 32'h0);
    @(negedge clk);
    checks++;
    if ({rsp_data0, rsp_data1} !== {32'h87654321, 32'h87654321}) begin
      errors++;
      $display("FAIL copy_readback: d0=%h d1=%h required 87654321/87654321",
               rsp_data0, rsp_data1);
    end
    @(negedge clk);
    // Self-copy rewrites the same value.
    send(2'b11, 5'h03, 5'h03, 32'h0);
    checks++;
    if ({we, wa, wd} !== {1'b1, 5'h03, 32'h87654321}) begin
      errors++;
      $display("FAIL copy_self: we=%b wa=%h wd=%h required 1/03/87654321", we, wa, wd);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clear;
    int we_cnt;
    int rsp_at;
    int bad;
    we_cnt = 0;
    rsp_at = -1;
    bad    = 0;
    send(2'b10, 5'h00, 5'h00, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (we === 1'b1) begin
        if (wa !== we_cnt[4:0] || wd !== 32'h0) bad++;
        we_cnt++;
      end
      if (rsp_valid === 1'b1) begin
        if (rsp_at < 0) rsp_at = i;
        else bad++;
        if (rsp_op !== 2'b10) bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (we_cnt != 32) begin
      errors++;
      $display("FAIL clear_we_count: got %0d required 32", we_cnt);
    end
    // Loop index 0 is cycle N+1, so N+33 is index 32.
    checks++;
    if (rsp_at != 32) begin
      errors++;
      $display("FAIL clear_rsp_cycle: index %0d required 32", rsp_at);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_sequence: %0d bad cycles required 0", bad);
    end
    send(2'b01, 5'h03, 5'h12, 32'h0);
    @(negedge clk);
    checks++;
    if ({rsp_data0, rsp_data1} !== 64'h0) begin
      errors++;
      $display("FAIL clear_readback: d0=%h d1=%h required 0/0", rsp_data0, rsp_data1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear;
    int rsp_seen;
    rsp_seen = 0;
    run_cmd(2'b00, 5'h03, 5'h00, 32'h12345678);
    run_cmd(2'b00, 5'h12, 5'h00, 32'h87654321);
    send(2'b10, 5'h00, 5'h00, 32'h0);
    // Cycles N+1..N+10 write entries 0..9; reset is sampled at the end of N+10.
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, we, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL midclear_reset: busy/we/rsp=%b required 000", {busy, we, rsp_valid});
    end
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1 || we === 1'b1) rsp_seen++;
      @(negedge clk);
    end
    checks++;
    if (rsp_seen != 0) begin
      errors++;
      $display("FAIL midclear_quiet: %0d rsp/we cycles required 0", rsp_seen);
    end
    send(2'b01, 5'h03, 5'h12, 32'h0);
    @(negedge clk);
    checks++;
    if ({rsp_data0, rsp_data1} !== {32'h0, 32'h87654321}) begin
      errors++;
      $display("FAIL midclear_readback: d0=%h d1=%h required 0/87654321",
               rsp_data0, rsp_data1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int accepts;
    int rsps;
    int wes;
    int bad;
    accepts = 0;
    rsps    = 0;
    wes     = 0;
    bad     = 0;
    cmd_op    = 2'b00;
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      // Present decoy fields while busy; only ready cycles carry the real command.
      if (cmd_ready === 1'b1) begin
        cmd_a    = 5'h05;
        cmd_data = 32'habcdef01;
        accepts++;
      end else begin
        cmd_a    = 5'h07;
        cmd_data = 32'hdeadbeef;
      end
      if (rsp_valid === 1'b1) rsps++;
      if (we === 1'b1) begin
        wes++;
        if (wa !== 5'h05 || wd !== 32'habcdef01) bad++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (accepts != 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d required 4", accepts);
    end
    checks++;
    if (rsps != 4 || wes != 4) begin
      errors++;
      $display("FAIL b2b_pulses: rsp %0d we %0d required 4/4", rsps, wes);
    end
    checks++;
    if (bad != 0 || mem[7] !== 32'h0 || mem[5] !== 32'habcdef01) begin
      errors++;
      $display("FAIL b2b_capture: bad=%0d mem7=%h mem5=%h required 0/0/abcdef01",
               bad, mem[7], mem[5]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mem_init  = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_copy();
    test_clear();
    test_reset_mid_clear();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
